// File: rtl/self_destruct_sequencer_pkg.sv
// Shared state codes and LED patterns for the self-destruct sequencer.
// Imported by the RTL and by the bench.
package self_destruct_sequencer_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ARMING    = 3'd1;
  localparam logic [2:0] COUNTDOWN = 3'd2;
  localparam logic [2:0] COOLDOWN  = 3'd3;
  localparam logic [2:0] DETONATED = 3'd4;

  localparam logic [3:0] LED_ALL_ON = 4'hF;
  localparam logic [3:0] LED_OFF    = 4'h0;

  typedef enum logic [2:0] {
    S_IDLE      = IDLE,
    S_ARMING    = ARMING,
    S_COUNTDOWN = COUNTDOWN,
    S_COOLDOWN  = COOLDOWN,
    S_DETONATED = DETONATED
  } state_e;

endpackage

// File: rtl/self_destruct_sequencer_tick_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for a slow async input.
// Reusable for any divider output that must become a one-cycle pulse.
module tick_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse_out
);

  logic       sync1;
  logic       sync2;
  logic       dly;
  logic [2:0] fill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
      fill  <= 3'b000;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      dly   <= sync2;
      fill  <= {fill[1:0], 1'b1};
    end
  end

  // fill[2] waits until dly holds a real sample, so a line that is
  // already high when reset is released is not taken as an edge.
  assign pulse_out = sync2 & ~dly & fill[2];

endmodule

// File: rtl/self_destruct_sequencer.sv
// Self-destruct FSM: arm, count down, cool down, detonate.
// Drives the four board LEDs from the 1 s tick and the two switches.
import self_destruct_sequencer_pkg::*;

module self_destruct_sequencer #(
  parameter int LIMIT     = 10,
  parameter int ARM_TICKS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       in_combat,
  input  logic       in_danger,
  output logic [3:0] leds,
  output logic [2:0] state_o,
  output logic       armed,
  output logic       boom
);

  localparam logic [3:0] LIM      = 4'(LIMIT);
  localparam logic [3:0] LIM_LAST = 4'(LIMIT - 1);
  localparam logic [3:0] ARM_LAST = 4'(ARM_TICKS - 1);

  logic       tick_p;
  logic       both;
  state_e     state;
  state_e     state_n;
  logic [3:0] cnt;
  logic [3:0] cnt_n;
  logic [3:0] arm_cnt;
  logic [3:0] arm_cnt_n;
  logic [3:0] leds_n;

  tick_edge_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .async_in  (tick_in),
    .pulse_out (tick_p)
  );

  assign both = in_combat & in_danger;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    arm_cnt_n = arm_cnt;
    unique case (state)
      S_IDLE: begin
        cnt_n = 4'd0;
        if (both) begin
          state_n   = S_ARMING;
          arm_cnt_n = 4'd0;
        end
      end
      S_ARMING: begin
        if (!both) begin
          state_n = S_IDLE;
        end else if (tick_p) begin
          if (arm_cnt >= ARM_LAST) begin
            state_n = S_COUNTDOWN;
            cnt_n   = 4'd0;
          end else begin
            arm_cnt_n = arm_cnt + 4'd1;
          end
        end
      end
      S_COUNTDOWN: begin
        if (!in_combat) begin
          state_n = S_COOLDOWN;
        end else if (tick_p && in_danger) begin
          if (cnt >= LIM_LAST) begin
            state_n = S_DETONATED;
            cnt_n   = LIM;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end
      end
      S_COOLDOWN: begin
        if (both) begin
          state_n = S_COUNTDOWN;
        end else if (cnt == 4'd0) begin
          state_n = S_IDLE;
        end else if (tick_p) begin
          cnt_n = cnt - 4'd1;
          if (cnt == 4'd1) state_n = S_IDLE;
        end
      end
      S_DETONATED: ;
      default: state_n = S_IDLE;
    endcase
  end

  // LEDs are registered from the next state so they line up with state_o.
  always_comb begin
    leds_n = LED_OFF;
    unique case (state_n)
      S_COUNTDOWN, S_COOLDOWN: leds_n = cnt_n;
      S_DETONATED: begin
        if (state != S_DETONATED) leds_n = LED_ALL_ON;
        else if (tick_p)          leds_n = ~leds;
        else                      leds_n = leds;
      end
      default: leds_n = LED_OFF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      arm_cnt <= 4'd0;
      leds    <= LED_OFF;
      armed   <= 1'b0;
      boom    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      arm_cnt <= arm_cnt_n;
      leds    <= leds_n;
      armed   <= (state_n == S_COUNTDOWN);
      boom    <= (state_n == S_DETONATED);
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_self_destruct_sequencer.sv
// Directed bench for self_destruct_sequencer with a small scoreboard.
// Expected outputs are queued with each stimulus step and popped at sample time.
import self_destruct_sequencer_pkg::*;

module tb_self_destruct_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick_in;
  logic       in_combat;
  logic       in_danger;
  logic [3:0] leds;
  logic [2:0] state_o;
  logic       armed;
  logic       boom;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      tag;
    logic [2:0] st;
    logic [3:0] ld;
    logic       ar;
    logic       bm;
  } exp_t;

  exp_t sb[$];

  self_destruct_sequencer #(.LIMIT(10), .ARM_TICKS(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_in   (tick_in),
    .in_combat (in_combat),
    .in_danger (in_danger),
    .leds      (leds),
    .state_o   (state_o),
    .armed     (armed),
    .boom      (boom)
  );

  always #5 clk = ~clk;

  task automatic want(string tag, logic [2:0] st, logic [3:0] ld,
                      logic ar, logic bm);
    exp_t e;
    e.tag = tag;
    e.st  = st;
    e.ld  = ld;
    e.ar  = ar;
    e.bm  = bm;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 entries expected>=1");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (state_o === e.st) else begin
        failures++;
        $error("FAIL %s state_o observed=%0d expected=%0d", e.tag, state_o, e.st);
      end
      checks++;
      assert (leds === e.ld) else begin
        failures++;
        $error("FAIL %s leds observed=%h expected=%h", e.tag, leds, e.ld);
      end
      checks++;
      assert (armed === e.ar) else begin
        failures++;
        $error("FAIL %s armed observed=%b expected=%b", e.tag, armed, e.ar);
      end
      checks++;
      assert (boom === e.bm) else begin
        failures++;
        $error("FAIL %s boom observed=%b expected=%b", e.tag, boom, e.bm);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk) tick_in = 1'b1;
    repeat (3) @(negedge clk);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    tick_in   = 1'b0;
    in_combat = 1'b0;
    in_danger = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic arm();
    in_combat = 1'b1;
    in_danger = 1'b1;
    repeat (2) @(negedge clk);
    want("arm_enter", ARMING, LED_OFF, 1'b0, 1'b0);
    check_out();
    repeat (3) tick();
    want("arm_done", COUNTDOWN, 4'd0, 1'b1, 1'b0);
    check_out();
  endtask

  initial begin
    reset     = 1'b1;
    tick_in   = 1'b1;
    in_combat = 1'b1;
    in_danger = 1'b1;
    repeat (3) @(negedge clk);
    want("reset_state", IDLE, LED_OFF, 1'b0, 1'b0);
    check_out();

    // tick_in already high at release must not count as an arming tick
    reset = 1'b0;
    repeat (6) @(negedge clk);
    want("hi_at_release", ARMING, LED_OFF, 1'b0, 1'b0);
    check_out();
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    repeat (2) tick();
    want("arm_two_ticks", ARMING, LED_OFF, 1'b0, 1'b0);
    check_out();
    tick();
    want("arm_third_tick", COUNTDOWN, 4'd0, 1'b1, 1'b0);
    check_out();

    // one-clock glitch gives a single tick
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk) tick_in = 1'b0;
    repeat (4) @(negedge clk);
    want("glitch_one_tick", COUNTDOWN, 4'd1, 1'b1, 1'b0);
    check_out();

    for (int i = 2; i <= 9; i++) begin
      want("count_up", COUNTDOWN, 4'(i), 1'b1, 1'b0);
      tick();
      check_out();
    end
    want("detonate", DETONATED, LED_ALL_ON, 1'b0, 1'b1);
    tick();
    check_out();

    in_combat = 1'b0;
    in_danger = 1'b0;
    repeat (3) @(negedge clk);
    want("det_ignores_sw", DETONATED, LED_ALL_ON, 1'b0, 1'b1);
    check_out();
    want("det_toggle_off", DETONATED, LED_OFF, 1'b0, 1'b1);
    tick();
    check_out();
    in_combat = 1'b1;
    in_danger = 1'b1;
    want("det_toggle_on", DETONATED, LED_ALL_ON, 1'b0, 1'b1);
    tick();
    check_out();

    // pause while danger is low, then async reset mid-countdown
    do_reset();
    arm();
    repeat (4) tick();
    want("count_to_4", COUNTDOWN, 4'd4, 1'b1, 1'b0);
    check_out();
    in_danger = 1'b0;
    for (int i = 0; i < 3; i++) begin
      want("paused", COUNTDOWN, 4'd4, 1'b1, 1'b0);
      tick();
      check_out();
    end
    in_danger = 1'b1;
    want("resume", COUNTDOWN, 4'd5, 1'b1, 1'b0);
    tick();
    check_out();
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    want("async_reset", IDLE, LED_OFF, 1'b0, 1'b0);
    check_out();
    @(negedge clk) reset = 1'b0;
    in_combat = 1'b0;
    in_danger = 1'b0;
    repeat (4) @(negedge clk);

    // cooldown back to idle
    arm();
    repeat (3) tick();
    in_combat = 1'b0;
    repeat (2) @(negedge clk);
    want("cooldown_enter", COOLDOWN, 4'd3, 1'b0, 1'b0);
    check_out();
    want("cool_2", COOLDOWN, 4'd2, 1'b0, 1'b0);
    tick();
    check_out();
    want("cool_1", COOLDOWN, 4'd1, 1'b0, 1'b0);
    tick();
    check_out();
    want("cool_idle", IDLE, LED_OFF, 1'b0, 1'b0);
    tick();
    check_out();

    // cooldown entered with cnt=0 leaves on the next clock
    arm();
    in_combat = 1'b0;
    @(negedge clk);
    want("cool_zero", COOLDOWN, 4'd0, 1'b0, 1'b0);
    check_out();
    @(negedge clk);
    want("cool_zero_idle", IDLE, LED_OFF, 1'b0, 1'b0);
    check_out();

    // combat drop coinciding with a tick
    arm();
    repeat (2) tick();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk) in_combat = 1'b0;
    @(negedge clk);
    want("drop_beats_tick", COOLDOWN, 4'd2, 1'b0, 1'b0);
    check_out();
    tick_in = 1'b0;
    in_combat = 1'b1;
    @(negedge clk);
    want("recount", COUNTDOWN, 4'd2, 1'b1, 1'b0);
    check_out();

    // danger drop coinciding with an arming tick
    do_reset();
    in_combat = 1'b1;
    in_danger = 1'b1;
    repeat (2) @(negedge clk);
    tick();
    want("arm_one", ARMING, LED_OFF, 1'b0, 1'b0);
    check_out();
    @(negedge clk) tick_in = 1'b1;
    @(negedge clk);
    @(negedge clk) in_danger = 1'b0;
    @(negedge clk);
    want("arm_abort", IDLE, LED_OFF, 1'b0, 1'b0);
    check_out();
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    in_danger = 1'b1;
    repeat (2) @(negedge clk);
    repeat (2) tick();
    want("rearm_two", ARMING, LED_OFF, 1'b0, 1'b0);
    check_out();
    tick();
    want("rearm_three", COUNTDOWN, 4'd0, 1'b1, 1'b0);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
